risac_dbus_uart_tx: RTL and testbench
=====================================

# risac_dbus_uart_tx

Memory-mapped UART transmitter on the risac data bus (DBUS), replacing the simulation-only virtual console at address 0x10000 with synthesizable hardware. The core writes bytes to TXDATA. Each byte is queued in a small FIFO and serialized as 8N1 on `oTx`. `oWait` stalls the core only when it writes while the FIFO is full. A STATUS register lets firmware poll instead of stalling.

## Interface
- `BASE_ADDR`, 32'h0001_0000: base address of the 8-byte register window (must be 8-byte aligned).
- `CLKS_PER_BIT`, 16: clock cycles per UART bit. Must be ≥ 2.
- `FIFO_DEPTH`, 8: TX FIFO entries. Must be a power of 2 and ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `iAddr`  in  32  DBUS byte address (core `oDbusAddr`).
- `iWe`  in  1  DBUS write strobe (core `oDbusWe`).
- `iData`  in  32  DBUS write data (core `oDbusData`).
- `iRead`  in  1  DBUS read strobe (core `oDbusRead`).
- `iByteEn`  in  4  DBUS byte enables (core `oDbusByteEn`).
- `oData`  out  32  read data, combinational, valid the same cycle as `iRead`.
- `oWait`  out  1  stall request to the core, combinational.
- `oSel`  out  1  high when `iAddr` falls in this block's window; used by the DBUS mux.
- `oTx`  out  1  serial output; idles high.

## Operation
- Select: `oSel = (iAddr[31:3] == BASE_ADDR[31:3])`.
- Register at offset 0x0, TXDATA (`iAddr[2]==0`):
  - Write with `iByteEn[0]` pushes `iData[7:0]`.
  - Writes without `iByteEn[0]` are ignored.
  - Reads return 0.
- Register at offset 0x4, STATUS (`iAddr[2]==1`), read-only; writes are ignored:
  - bit0 = full.
  - bit1 = empty.
  - bit2 = busy, meaning the state is not IDLE.
  - bits[15:8] = FIFO count.
  - All other bits read 0.
- `oData` is 0 whenever `oSel` or `iRead` is low.
- Push condition: `oSel & iWe & ~iAddr[2] & iByteEn[0] & ~full`.
- `oWait = oSel & iWe & ~iAddr[2] & iByteEn[0] & full`.
  - `full` is the registered flag, so a write that meets a full FIFO waits at least one cycle, even if a pop happens in that same cycle.
  - While stalled, the core holds the bus. The push happens on the first edge where `full` is low.
- Reads never wait.
- FIFO:
  - Circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A simultaneous push and pop leaves the count unchanged.
- Transmit state machine, states IDLE, START, DATA, STOP:
  - A baud counter counts 0..CLKS_PER_BIT-1. A bit counter counts 0..7.
  - IDLE: `oTx=1`. If the FIFO is non-empty: pop the head into the shift register, clear the baud counter, go to START.
  - START: `oTx=0` for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `oTx = shift[0]`. At the end of each bit, shift right and increment the bit counter. After bit 7 completes, go to STOP.
  - STOP: `oTx=1` for CLKS_PER_BIT cycles. On the last stop cycle:
    - if the FIFO is non-empty, pop and go directly to START, so back-to-back frames have no idle gap;
    - otherwise go to IDLE.
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE; all counters and pointers clear; the FIFO empties.
  - `oTx=1`, `oWait=0`, `oData=0`.
  - Queued bytes are discarded, and a partial frame is truncated to idle-high.

## Timing
- Push latency: a byte written on edge N is in the FIFO after N.
- If the FIFO was empty and the state was IDLE, that byte is popped at edge N+1 and `oTx` falls after edge N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles: 1 start bit, 8 data bits LSB-first, 1 stop bit.
- Two bytes queued back-to-back produce 20·CLKS_PER_BIT cycles of contiguous line activity.
- STATUS reflects the registered state before the current edge. A push made at edge N is visible in the count from cycle N+1.
- `oWait` depends only on the current bus inputs and registered `full`; it has no combinational path from `oTx` state.

## Test plan
- Reset: hold `rst_n=0` → `oTx=1`, `oWait=0`, STATUS = 0x0000_0002.
- Single byte: with CLKS_PER_BIT=16, write 0x41 to 0x10000 with byte enables 0x1.
  - `oTx` low for cycles 1–16 after the pop.
  - Data bits 1,0,0,0,0,0,1,0, 16 cycles each.
  - High stop bit; frame is 160 cycles total.
  - busy clears after the stop bit.
- Back-to-back: write 0x55 then 0xAA on consecutive cycles → no idle cycle between the stop bit and the next start bit; 320 cycles of line activity.
- Full stall: write 9 bytes with FIFO_DEPTH=8.
  - Write 1 pops immediately, so writes 2–9 fill the FIFO (count 8, full=1).
  - A 10th write holds `oWait=1` until the first frame ends, then lands; count returns to 8.
- Byte enables and reads:
  - Write with byte enables 0x2 to TXDATA → no push.
  - Read TXDATA → 0.
  - Access to address 0x10008 → `oSel=0`, no effect.
  - STATUS count matches the number of pending bytes.
- Mid-frame reset: assert `rst_n` low during the DATA state → `oTx=1` immediately; after release, STATUS=0x2 and nothing further is transmitted.

Source files
------------

// File: rtl/risac_dbus_uart_tx.sv
// risac DBUS UART transmitter: TXDATA/STATUS window, TX FIFO, 8N1 serializer.
// Ports: clk, rst_n, DBUS in (iAddr/iWe/iData/iRead/iByteEn), oData/oWait/oSel, oTx.
module risac_dbus_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] iAddr,
    input  logic        iWe,
    input  logic [31:0] iData,
    input  logic        iRead,
    input  logic [3:0]  iByteEn,
    output logic [31:0] oData,
    output logic        oWait,
    output logic        oSel,
    output logic        oTx
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CNW = AW + 1;
    localparam int BW  = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t         r_state;
    logic [BW-1:0]  r_baud;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic           r_tx;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CNW-1:0] r_count;

    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_wr_tx;
    logic        w_push;
    logic        w_pop;
    logic        w_bit_end;
    logic [7:0]  w_head;
    logic [7:0]  w_cnt8;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_unused = ^{iData[31:8], iByteEn[3:1], iAddr[1:0]};

    assign oSel    = (iAddr[31:3] == BASE_ADDR[31:3]);
    assign w_full  = (r_count == CNW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_busy  = (r_state != S_IDLE);
    assign w_head  = r_mem[r_rptr];

    // Stall is driven only from registered full, never from the pop path.
    assign w_wr_tx = oSel & iWe & ~iAddr[2] & iByteEn[0];
    assign w_push  = w_wr_tx & ~w_full;
    assign oWait   = w_wr_tx & w_full;

    assign w_bit_end = (r_baud == BAUD_LAST);
    // Pop from IDLE, or on the last stop cycle to chain frames gaplessly.
    assign w_pop = ~w_empty & ((r_state == S_IDLE) |
                   ((r_state == S_STOP) & w_bit_end));

    assign w_cnt8   = 8'(r_count);
    assign w_status = {16'h0, w_cnt8, 5'h0, w_busy, w_empty, w_full};

    always_comb begin
        oData = 32'h0;
        if (oSel && iRead && iAddr[2]) begin
            oData = w_status;
        end
    end

    assign oTx = r_tx;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= iData[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift <= w_head;
                            r_bit   <= '0;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_risac_dbus_uart_tx.sv
// Directed bench for risac_dbus_uart_tx: frames, chaining, stall, enables, reset.
// Drives the DBUS one step at a time and checks oTx/oWait/oSel/oData.
module tb_risac_dbus_uart_tx;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] STAT = 32'h0001_0004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] iAddr;
    logic        iWe;
    logic [31:0] iData;
    logic        iRead;
    logic [3:0]  iByteEn;
    logic [31:0] oData;
    logic        oWait;
    logic        oSel;
    logic        oTx;

    int nvec = 0;
    int nerr = 0;

    risac_dbus_uart_tx #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(16),
        .FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .iAddr(iAddr),
        .iWe(iWe),
        .iData(iData),
        .iRead(iRead),
        .iByteEn(iByteEn),
        .oData(oData),
        .oWait(oWait),
        .oSel(oSel),
        .oTx(oTx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] be);
        iAddr   = a;
        iData   = d;
        iByteEn = be;
        iWe     = 1'b1;
        @(posedge clk);
        #1;
        iWe = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        iAddr = a;
        iRead = 1'b1;
        #1;
        d     = oData;
        iRead = 1'b0;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic frame_check(input string tag, input logic [7:0] b);
        for (int c = 0; c < 160; c++) begin
            chk(tag, {31'h0, oTx}, {31'h0, exp_bit(b, c / 16)});
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] s;
    int          cnt;
    int          bad;

    initial begin
        rst_n   = 1'b0;
        iAddr   = 32'h0;
        iWe     = 1'b0;
        iData   = 32'h0;
        iRead   = 1'b0;
        iByteEn = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'h0, oTx}, 32'h1);
        chk("rst_wait", {31'h0, oWait}, 32'h0);
        rd(STAT, s);
        chk("rst_status", s, 32'h2);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        wr(BASE, 32'h41, 4'h1);
        rd(STAT, s);
        chk("push_status", s, 32'h0000_0100);
        @(posedge clk);
        #1;
        rd(STAT, s);
        chk("busy_status", s, 32'h0000_0006);
        frame_check("frame41", 8'h41);
        rd(STAT, s);
        chk("idle_status", s, 32'h2);
        chk("idle_tx", {31'h0, oTx}, 32'h1);

        wr(BASE, 32'h55, 4'h1);
        wr(BASE, 32'hAA, 4'h1);
        frame_check("b2b55", 8'h55);
        frame_check("b2bAA", 8'hAA);
        rd(STAT, s);
        chk("b2b_idle", s, 32'h2);
        chk("b2b_tx", {31'h0, oTx}, 32'h1);

        for (int i = 0; i < 9; i++) begin
            wr(BASE, (i == 1) ? 32'h00 : 32'h10 + i, 4'h1);
        end
        rd(STAT, s);
        chk("full_status", s, 32'h0000_0805);
        iAddr   = BASE;
        iData   = 32'h99;
        iByteEn = 4'h1;
        iWe     = 1'b1;
        #1;
        chk("stall_wait", {31'h0, oWait}, 32'h1);
        cnt = 0;
        while (oWait && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("stall_cycles", cnt, 32'd153);
        @(posedge clk);
        #1;
        iWe = 1'b0;
        rd(STAT, s);
        chk("refill_status", s, 32'h0000_0805);

        repeat (30) @(posedge clk);
        #1;
        chk("pre_rst_tx", {31'h0, oTx}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", {31'h0, oTx}, 32'h1);
        chk("mid_rst_wait", {31'h0, oWait}, 32'h0);
        rd(STAT, s);
        chk("mid_rst_status", s, 32'h2);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (oTx !== 1'b1) bad++;
        end
        chk("post_rst_quiet", bad, 32'd0);
        rd(STAT, s);
        chk("post_rst_status", s, 32'h2);

        wr(BASE, 32'h33, 4'h2);
        chk("be2_wait", {31'h0, oWait}, 32'h0);
        rd(STAT, s);
        chk("be2_nopush", s, 32'h2);
        rd(BASE, s);
        chk("rd_txdata", s, 32'h0);
        chk("sel_base", {31'h0, oSel}, 32'h1);
        iAddr = 32'h0001_0008;
        #1;
        chk("sel_out", {31'h0, oSel}, 32'h0);
        wr(32'h0001_0008, 32'h44, 4'h1);
        rd(32'h0001_000C, s);
        chk("rd_outside", s, 32'h0);
        wr(STAT, 32'h45, 4'h1);
        iAddr = STAT;
        #1;
        chk("rd_noread", oData, 32'h0);
        rd(STAT, s);
        chk("outside_nopush", s, 32'h2);
        @(posedge clk);
        #1;
        chk("nopush_tx", {31'h0, oTx}, 32'h1);

        wr(BASE, 32'h01, 4'h1);
        wr(BASE, 32'h02, 4'h1);
        wr(BASE, 32'h03, 4'h1);
        rd(STAT, s);
        chk("pending_count", s, 32'h0000_0204);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
